io_input_responder: RTL and testbench

- Memory-mapped responder for CPU reads of board inputs: 24 DIP switches and NUM_BTN push buttons.
- Synchronises and debounces the inputs, then latches press and switch-change events in write-1-to-clear flags. Keeps a press counter.
- Sits beside the data RAM on the mini_rv data bus. Supplies read data combinationally plus a hit strobe, so the top level can mux it against RAM read data within the same single cycle.

---
 rtl/io_input_responder.sv | 242 ++++++++++++++++++++++++
 tb/tb_io_input_responder.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_input_responder.sv
// -----------------------------------------------------------------------------
// io_input_responder
//
// Memory-mapped responder for CPU reads of board inputs (DIP switches and push
// buttons) on the mini_rv data bus. Raw pins are synchronised through two
// flops. Buttons are then debounced. Button presses and switch changes are
// latched in write-1-to-clear event flags, and a press counter is kept.
// Read data and the hit strobe are combinational from addr so the top level
// can mux them against RAM read data within the same cycle.
//
// Register map (byte offsets from BASE_ADDR, addr[1:0] ignored):
//   0x00 SW    zero-extended synchronised switches   (read only)
//   0x04 BTN   zero-extended debounced buttons       (read only)
//   0x08 EVT   [NUM_BTN-1:0] press flags, [8] switch change, W1C
//   0x0C PCNT  press counter, any write clears
//   0x10 IMASK interrupt mask, layout as EVT (only with IO_IRQ_EN)
//
// Optional feature macro: IO_IRQ_EN
//   defined   -> IMASK register exists and irq is a registered event interrupt
//   undefined -> 0x10 is unmapped and irq is tied low
//
// Ports:
//   clk     in   CPU clock, all state on the rising edge
//   rst_n   in   asynchronous active-low reset
//   addr    in   32-bit bus byte address
//   we      in   bus write enable
//   wdata   in   32-bit bus write data
//   switch  in   SW_WIDTH raw asynchronous switch pins
//   button  in   NUM_BTN raw asynchronous button pins, 1 = pressed
//   rdata   out  32-bit read data, combinational from addr
//   hit     out  addr selects a register of this block
//   irq     out  event interrupt
// -----------------------------------------------------------------------------
module io_input_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'hffff_f070,
  parameter int          SW_WIDTH        = 24,
  parameter int          NUM_BTN         = 5,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         addr,
  input  logic                we,
  input  logic [31:0]         wdata,
  input  logic [SW_WIDTH-1:0] switch,
  input  logic [NUM_BTN-1:0]  button,
  output logic [31:0]         rdata,
  output logic                hit,
  output logic                irq
);

  localparam int              DB_W      = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [29:0]     BASE_WORD = BASE_ADDR[31:2];
  localparam logic [7:0]      BTN_MASK  = 8'((9'd1 << NUM_BTN) - 9'd1);
  // Only implemented EVT bits can ever be set or read back as 1.
  localparam logic [8:0]      EVT_MASK  = {1'b1, BTN_MASK};

  // ---------------------------------------------------------------------------
  // Address decode (word granular)
  // ---------------------------------------------------------------------------
  logic [29:0] word_s;
  logic        sel_sw_s;
  logic        sel_btn_s;
  logic        sel_evt_s;
  logic        sel_pcnt_s;

  assign word_s     = addr[31:2];
  assign sel_sw_s   = (word_s == BASE_WORD);
  assign sel_btn_s  = (word_s == BASE_WORD + 30'd1);
  assign sel_evt_s  = (word_s == BASE_WORD + 30'd2);
  assign sel_pcnt_s = (word_s == BASE_WORD + 30'd3);

  // Bits that never take part in decode or register writes.
  logic unused_s;
  assign unused_s = ^{addr[1:0], wdata[31:9]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SW_WIDTH-1:0]           sw_meta_q;
  logic [SW_WIDTH-1:0]           sw_s_q;
  logic [SW_WIDTH-1:0]           sw_prev_q;
  logic [NUM_BTN-1:0]            btn_meta_q;
  logic [NUM_BTN-1:0]            btn_s_q;
  logic [NUM_BTN-1:0]            stable_q;
  logic [NUM_BTN-1:0]            stable_d;
  logic [NUM_BTN-1:0][DB_W-1:0]  db_cnt_q;
  logic [NUM_BTN-1:0][DB_W-1:0]  db_cnt_d;
  logic [8:0]                    evt_q;
  logic [8:0]                    evt_d;
  logic [CNT_W-1:0]              pcnt_q;
  logic [CNT_W-1:0]              pcnt_d;

  logic [NUM_BTN-1:0]            press_s;
  logic [7:0]                    press_ext_s;
  logic                          sw_chg_s;
  logic [8:0]                    evt_set_s;
  logic [8:0]                    evt_clr_s;

  // Two-flop synchronisers for the raw pins plus the switch change reference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      sw_prev_q  <= '0;
      btn_meta_q <= '0;
      btn_s_q    <= '0;
    end else begin
      sw_meta_q  <= switch;
      sw_s_q     <= sw_meta_q;
      sw_prev_q  <= sw_s_q;
      btn_meta_q <= button;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Debounce: a button's stable value flips only after the synchronised input
  // has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_s_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = btn_s_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end else begin
        // Agreement (including a bounce back) restarts the count.
        db_cnt_d[i] = '0;
      end
    end
  end

  // Event flag and press counter next state
  always_comb begin
    press_s        = stable_d & ~stable_q;
    press_ext_s    = 8'd0;
    press_ext_s[NUM_BTN-1:0] = press_s;
    sw_chg_s       = (sw_s_q != sw_prev_q);
    evt_set_s      = {sw_chg_s, press_ext_s};
    if (we && sel_evt_s) begin
      evt_clr_s = wdata[8:0];
    end else begin
      evt_clr_s = 9'd0;
    end
    // Set is applied after clear so a colliding set wins.
    evt_d = ((evt_q & ~evt_clr_s) | evt_set_s) & EVT_MASK;

    if (we && sel_pcnt_s) begin
      pcnt_d = '0;
    end else if (|press_s) begin
      // Simultaneous presses count once; natural wrap at 2^CNT_W.
      pcnt_d = pcnt_q + CNT_W'(1);
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Debounced state, event flags and press counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= '0;
      db_cnt_q <= '0;
      evt_q    <= 9'd0;
      pcnt_q   <= '0;
    end else begin
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
      evt_q    <= evt_d;
      pcnt_q   <= pcnt_d;
    end
  end

`ifdef IO_IRQ_EN
  // ---------------------------------------------------------------------------
  // Interrupt mask and registered interrupt
  // ---------------------------------------------------------------------------
  logic       sel_imask_s;
  logic [8:0] imask_q;
  logic [8:0] imask_d;
  logic       irq_q;

  assign sel_imask_s = (word_s == BASE_WORD + 30'd4);

  // Interrupt mask next state
  always_comb begin
    if (we && sel_imask_s) begin
      imask_d = wdata[8:0] & EVT_MASK;
    end else begin
      imask_d = imask_q;
    end
  end

  // Mask register and interrupt; irq tracks the flags being committed this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imask_q <= 9'd0;
      irq_q   <= 1'b0;
    end else begin
      imask_q <= imask_d;
      irq_q   <= |(evt_d & imask_d);
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Combinational read mux; unmapped words return zero with no hit
  always_comb begin
    rdata = 32'd0;
    hit   = 1'b0;
    if (sel_sw_s) begin
      hit = 1'b1;
      rdata[SW_WIDTH-1:0] = sw_s_q;
    end else if (sel_btn_s) begin
      hit = 1'b1;
      rdata[NUM_BTN-1:0] = stable_q;
    end else if (sel_evt_s) begin
      hit = 1'b1;
      rdata[8:0] = evt_q;
    end else if (sel_pcnt_s) begin
      hit = 1'b1;
      rdata[CNT_W-1:0] = pcnt_q;
`ifdef IO_IRQ_EN
    end else if (sel_imask_s) begin
      hit = 1'b1;
      rdata[8:0] = imask_q;
`endif
    end else begin
      hit   = 1'b0;
      rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_io_input_responder.sv
// -----------------------------------------------------------------------------
// Testbench for io_input_responder (DEBOUNCE_CYCLES=4, CNT_W=2).
// A behavioural model (sample queues, debounce history window, flag/counter
// arithmetic) is advanced every cycle and compared with rdata/hit/irq at each
// falling edge. Directed scenarios add hand-computed literal expectations, then
// a randomized phase exercises pins and bus traffic.
// -----------------------------------------------------------------------------
module tb_io_input_responder;

  localparam logic [31:0] BASE = 32'hffff_f070;
  localparam int SW_W = 24;
  localparam int NB   = 5;
  localparam int DC   = 4;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   addr = 32'd0;
  logic          we = 1'b0;
  logic [31:0]   wdata = 32'd0;
  logic [SW_W-1:0] switch = '0;
  logic [NB-1:0] button = '0;
  logic [31:0]   rdata;
  logic          hit;
  logic          irq;

  always #5 clk = ~clk;

  io_input_responder #(
    .BASE_ADDR(BASE), .SW_WIDTH(SW_W), .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(DC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .we(we), .wdata(wdata),
    .switch(switch), .button(button), .rdata(rdata), .hit(hit), .irq(irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- inputs as seen by the DUT at each rising edge -----------
  logic [SW_W-1:0] s_sw;
  logic [NB-1:0]   s_btn;
  logic            s_we;
  logic            s_rst;
  logic [31:0]     s_addr;
  logic [31:0]     s_wd;

  always @(posedge clk) begin
    s_sw   <= switch;
    s_btn  <= button;
    s_we   <= we;
    s_addr <= addr;
    s_wd   <= wdata;
    s_rst  <= rst_n;
  end

  // ---------------- behavioural model ---------------------------------------
  logic [SW_W-1:0] m_sw_smp [$];
  logic [NB-1:0]   m_btn_smp [$];
  logic [NB-1:0]   m_bhist [$];
  logic [SW_W-1:0] m_sw_s, m_sw_prev;
  logic [NB-1:0]   m_btn_s, m_stable;
  logic [8:0]      m_evt;
  int              m_pcnt;
  logic [8:0]      m_imask;
  logic            m_irq;

  function automatic logic [31:0] word_off(input logic [31:0] a);
    return {2'b00, a[31:2]} - (BASE >> 2);
  endfunction

  task automatic model_reset();
    m_sw_smp.delete();  m_sw_smp.push_back('0);  m_sw_smp.push_back('0);
    m_btn_smp.delete(); m_btn_smp.push_back('0); m_btn_smp.push_back('0);
    m_bhist.delete();
    m_sw_s = '0; m_sw_prev = '0; m_btn_s = '0; m_stable = '0;
    m_evt = 9'd0; m_pcnt = 0; m_imask = 9'd0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    logic [NB-1:0] new_stable, press;
    logic          sw_chg;
    logic [8:0]    clr;
    bit            all_diff;
    // Buttons: flip once the last DC synchronised samples all disagree.
    m_bhist.push_front(m_btn_s);
    if (m_bhist.size() > DC) void'(m_bhist.pop_back());
    new_stable = m_stable;
    for (int i = 0; i < NB; i++) begin
      all_diff = (m_bhist.size() == DC);
      foreach (m_bhist[k]) if (m_bhist[k][i] == m_stable[i]) all_diff = 0;
      if (all_diff) new_stable[i] = ~m_stable[i];
    end
    press  = new_stable & ~m_stable;
    sw_chg = (m_sw_s != m_sw_prev);
    // Synchronised values equal the pins sampled one edge earlier.
    m_sw_smp.push_front(s_sw);   void'(m_sw_smp.pop_back());
    m_btn_smp.push_front(s_btn); void'(m_btn_smp.pop_back());
    m_sw_prev = m_sw_s;
    m_sw_s    = m_sw_smp[1];
    m_btn_s   = m_btn_smp[1];
    m_stable  = new_stable;
    clr = (s_we && word_off(s_addr) == 32'd2) ? s_wd[8:0] : 9'd0;
    m_evt = ((m_evt & ~clr) | {sw_chg, 3'b000, press}) & 9'h11F;
    if (s_we && word_off(s_addr) == 32'd3) m_pcnt = 0;
    else if (press != '0) m_pcnt = (m_pcnt + 1) % (1 << CW);
`ifdef IO_IRQ_EN
    if (s_we && word_off(s_addr) == 32'd4) m_imask = s_wd[8:0] & 9'h11F;
    m_irq = |(m_evt & m_imask);
`endif
  endtask

  function automatic void model_read(input logic [31:0] a, output logic [31:0] d, output logic h);
    d = 32'd0;
    h = 1'b1;
    case (word_off(a))
      32'd0: d = {8'd0, m_sw_s};
      32'd1: d = {27'd0, m_stable};
      32'd2: d = {23'd0, m_evt};
      32'd3: d = 32'(m_pcnt);
`ifdef IO_IRQ_EN
      32'd4: d = {23'd0, m_imask};
`endif
      default: h = 1'b0;
    endcase
  endfunction

  // Per-cycle compare process
  initial begin
    logic [31:0] ed;
    logic        eh;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n || !s_rst) model_reset();
      else model_step();
      model_read(addr, ed, eh);
      chk("model_rdata", rdata, ed);
      chk("model_hit", 32'(hit), 32'(eh));
      chk("model_irq", 32'(irq), 32'(m_irq));
    end
  end

  // ---------------- driver helpers ------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic h);
    addr = a;
    #1;
    d = rdata;
    h = hit;
  endtask

  task automatic press_release(input int b);
    button[b] = 1'b1;
    repeat (8) tick();
    button[b] = 1'b0;
    repeat (8) tick();
  endtask

  // Counts edges until a BTN bit goes high; 0 means it never did.
  task automatic edges_to_btn(input int b, output int n);
    logic [31:0] d;
    logic        h;
    n = 0;
    for (int k = 1; k <= 20 && n == 0; k++) begin
      tick();
      rd(BASE + 32'h4, d, h);
      if (d[b]) n = k;
    end
  endtask

  // ---------------- main sequence -------------------------------------------
  initial begin
    logic [31:0] d;
    logic        h;
    int          n;

    // Reset then read
    switch = 24'h00A5A5;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    rd(BASE, d, h);
    chk("sw_read", d, 32'h0000A5A5);
    chk("sw_hit", 32'(h), 32'd1);
    rd(BASE + 32'h4, d, h);
    chk("btn_reset", d, 32'd0);
    rd(BASE + 32'h20, d, h);
    chk("unmapped_hit", 32'(h), 32'd0);
    chk("unmapped_rdata", d, 32'd0);
    wr(BASE + 32'h8, 32'h1FF);
    wr(BASE + 32'hC, 32'd0);

    // Clean press: stable 6 edges after the pin edge
    button[0] = 1'b1;
    edges_to_btn(0, n);
    chk("debounce_edges", 32'(n), 32'd6);
    rd(BASE + 32'h8, d, h);
    chk("evt_press0", d, 32'h1);
    rd(BASE + 32'hC, d, h);
    chk("pcnt_one", d, 32'd1);
    button[0] = 1'b0;
    repeat (8) tick();
    rd(BASE + 32'h8, d, h);
    chk("release_no_evt", d, 32'h1);

    // Bounce on button 2
    wr(BASE + 32'h8, 32'h1FF);
    wr(BASE + 32'hC, 32'd0);
    button[2] = 1'b1; repeat (3) tick();
    button[2] = 1'b0; tick();
    button[2] = 1'b1;
    edges_to_btn(2, n);
    chk("bounce_edges", 32'(n), 32'd6);
    repeat (4) tick();
    rd(BASE + 32'h8, d, h);
    chk("bounce_evt", d, 32'h4);
    rd(BASE + 32'hC, d, h);
    chk("bounce_pcnt", d, 32'd1);
    button[2] = 1'b0;
    repeat (8) tick();
    rd(BASE + 32'h8, d, h);
    chk("bounce_release", d, 32'h4);

    // Simultaneous presses
    wr(BASE + 32'h8, 32'h1FF);
    wr(BASE + 32'hC, 32'd0);
    button[1] = 1'b1; button[3] = 1'b1;
    repeat (8) tick();
    rd(BASE + 32'h8, d, h);
    chk("simul_evt", d, 32'h0A);
    rd(BASE + 32'hC, d, h);
    chk("simul_pcnt", d, 32'd1);
    wr(BASE + 32'h8, 32'h02);
    rd(BASE + 32'h8, d, h);
    chk("w1c_partial", d, 32'h08);
    wr(BASE + 32'h0, 32'hFFFF_FFFF);   // read-only, ignored
    rd(BASE + 32'h0, d, h);
    chk("sw_write_ignored", d, 32'h0000A5A5);
    button[1] = 1'b0; button[3] = 1'b0;
    repeat (8) tick();

    // Set/clear collision on bit 0
    wr(BASE + 32'h8, 32'h1FF);
    button[0] = 1'b1;
    repeat (5) tick();
    wr(BASE + 32'h8, 32'h1);
    rd(BASE + 32'h4, d, h);
    chk("collide_btn", d, 32'h1);
    rd(BASE + 32'h8, d, h);
    chk("collide_evt", d, 32'h1);
    button[0] = 1'b0;
    repeat (8) tick();

    // Counter wrap with CNT_W=2
    wr(BASE + 32'hC, 32'd0);
    repeat (3) press_release(4);
    rd(BASE + 32'hC, d, h);
    chk("pcnt_three", d, 32'd3);
    press_release(4);
    rd(BASE + 32'hC, d, h);
    chk("pcnt_wrap", d, 32'd0);
    press_release(4);
    wr(BASE + 32'hC, 32'h1234);
    rd(BASE + 32'hC, d, h);
    chk("pcnt_clear", d, 32'd0);

`ifdef IO_IRQ_EN
    wr(BASE + 32'h10, 32'h100);
    wr(BASE + 32'h8, 32'h1FF);
    chk("irq_idle", 32'(irq), 32'd0);
    switch[7] = ~switch[7];
    n = 0;
    for (int k = 1; k <= 10 && n == 0; k++) begin
      tick();
      rd(BASE + 32'h8, d, h);
      if (d[8]) n = k;
    end
    chk("swchg_edges", 32'(n), 32'd3);
    chk("irq_set", 32'(irq), 32'd1);
    wr(BASE + 32'h8, 32'h100);
    chk("irq_clr", 32'(irq), 32'd0);
`else
    switch[7] = ~switch[7];
    repeat (5) tick();
    chk("irq_tied", 32'(irq), 32'd0);
    rd(BASE + 32'h10, d, h);
    chk("imask_unmapped_hit", 32'(h), 32'd0);
    chk("imask_unmapped_rdata", d, 32'd0);
`endif

    // Randomized phase
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) button = button ^ NB'(1 << $urandom_range(0, NB - 1));
      if (r >= 96) begin
        int b;
        b = $urandom_range(0, SW_W - 1);
        switch[b] = ~switch[b];
      end
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      else addr = BASE - 32'h4 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3));
      we    = ($urandom_range(0, 3) == 0);
      wdata = $urandom;
      tick();
    end
    we = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
